// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: bus direction, strobe levels,
// owner/state codes and the grant-selection rule.
package mem_bus_arbiter_pkg;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        BUS_OWNER_IDLE = 2'd0,
        BUS_OWNER_IF   = 2'd1,
        BUS_OWNER_MEM  = 2'd2
    } bus_owner_e;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    // Under contention the requester that did not win last time gets the bus.
    function automatic bus_owner_e pick_owner(input logic if_req, input logic mem_req,
                                              input grant_e last);
        if (if_req && mem_req) return (last == GRANT_IF) ? BUS_OWNER_MEM : BUS_OWNER_IF;
        if (if_req)            return BUS_OWNER_IF;
        if (mem_req)           return BUS_OWNER_MEM;
        return BUS_OWNER_IDLE;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the arbiter; master is the arbiter's
// view, slave is the view of the pipeline stages and memory around it.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              if_as_;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rd_data;
    logic              if_rdy;

    logic              mem_as_;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rdy;

    logic              bus_as_;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy;
    logic              bus_err;

    modport master (
        input  if_as_, if_addr,
        output if_rd_data, if_rdy,
        input  mem_as_, mem_rw, mem_addr, mem_wr_data,
        output mem_rd_data, mem_rdy,
        output bus_as_, bus_rw, bus_addr, bus_wr_data, bus_err,
        input  bus_rd_data, bus_rdy
    );

    modport slave (
        output if_as_, if_addr,
        input  if_rd_data, if_rdy,
        output mem_as_, mem_rw, mem_addr, mem_wr_data,
        input  mem_rd_data, mem_rdy,
        input  bus_as_, bus_rw, bus_addr, bus_wr_data, bus_err,
        output bus_rd_data, bus_rdy
    );

endinterface

// File: rtl/mem_bus_arbiter_bus_wait_timer.sv
// Per-transaction wait counter; expire is high once TIMEOUT-1 wait cycles
// have elapsed and holds there until the next clear.
module bus_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_p1;

    // Saturates at LAST so an idle arbiter never wraps the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else if (clear) begin
            cnt_p1 <= '0;
        end else if (enable && !expire) begin
            cnt_p1 <= cnt_p1 + CNT_W'(1);
        end
    end

    assign expire = (cnt_p1 == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between instruction fetch and the data
// stage: grants one owner, registers its access, waits with a timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.master mbus
);

    bus_owner_e        state_q;
    bus_owner_e        state_d;
    bus_owner_e        pick;
    grant_e            last_grant_q;

    logic              bus_as_p1;
    logic              bus_rw_p1;
    logic [ADDR_W-1:0] bus_addr_p1;
    logic [DATA_W-1:0] bus_wr_data_p1;

    logic              owning;
    logic              grant;
    logic              done;
    logic              expire;

    logic              if_rdy_c;
    logic              mem_rdy_c;
    logic [DATA_W-1:0] if_rd_data_c;
    logic [DATA_W-1:0] mem_rd_data_c;
    logic              bus_err_c;

    always_comb begin
        pick = pick_owner(!mbus.if_as_, !mbus.mem_as_, last_grant_q);
    end

    assign owning = (state_q != BUS_OWNER_IDLE);
    assign grant  = (state_q == BUS_OWNER_IDLE) && (pick != BUS_OWNER_IDLE);
    // bus_rdy on the expire cycle still counts as a normal completion.
    assign done   = owning && (mbus.bus_rdy || expire);

    bus_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant),
        .enable (owning && !mbus.bus_rdy),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUS_OWNER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_OWNER_IDLE: state_d = pick;
            BUS_OWNER_IF,
            BUS_OWNER_MEM:  if (done) state_d = BUS_OWNER_IDLE;
            default:        state_d = BUS_OWNER_IDLE;
        endcase
    end

    always_comb begin
        if_rdy_c      = 1'b0;
        mem_rdy_c     = 1'b0;
        if_rd_data_c  = '0;
        mem_rd_data_c = '0;
        bus_err_c     = 1'b0;
        case (state_q)
            BUS_OWNER_IF: begin
                if_rdy_c     = mbus.bus_rdy || expire;
                if_rd_data_c = mbus.bus_rdy ? mbus.bus_rd_data : '0;
                bus_err_c    = expire && !mbus.bus_rdy;
            end
            BUS_OWNER_MEM: begin
                mem_rdy_c     = mbus.bus_rdy || expire;
                mem_rd_data_c = mbus.bus_rdy ? mbus.bus_rd_data : '0;
                bus_err_c     = expire && !mbus.bus_rdy;
            end
            default: ;
        endcase
    end

    // Bus fields are captured only at grant and held for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_as_p1      <= DISABLE_;
            bus_rw_p1      <= READ;
            bus_addr_p1    <= '0;
            bus_wr_data_p1 <= '0;
            last_grant_q   <= GRANT_IF;
        end else if (grant) begin
            bus_as_p1 <= ENABLE_;
            if (pick == BUS_OWNER_IF) begin
                bus_rw_p1      <= READ;
                bus_addr_p1    <= mbus.if_addr;
                bus_wr_data_p1 <= '0;
            end else begin
                bus_rw_p1      <= mbus.mem_rw;
                bus_addr_p1    <= mbus.mem_addr;
                bus_wr_data_p1 <= mbus.mem_wr_data;
            end
        end else if (done) begin
            bus_as_p1    <= DISABLE_;
            last_grant_q <= (state_q == BUS_OWNER_IF) ? GRANT_IF : GRANT_MEM;
        end
    end

    assign mbus.bus_as_     = bus_as_p1;
    assign mbus.bus_rw      = bus_rw_p1;
    assign mbus.bus_addr    = bus_addr_p1;
    assign mbus.bus_wr_data = bus_wr_data_p1;
    assign mbus.bus_err     = bus_err_c;
    assign mbus.if_rdy      = if_rdy_c;
    assign mbus.if_rd_data  = if_rd_data_c;
    assign mbus.mem_rdy     = mem_rdy_c;
    assign mbus.mem_rd_data = mem_rd_data_c;

    a_rdy_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(if_rdy_c && mem_rdy_c));
    a_err_with_rdy: assert property (@(posedge clk) disable iff (rst)
        bus_err_c |-> (if_rdy_c || mem_rdy_c));

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences and shares the CPU's single memory port between two requesters: instruction fetch (read-only) and the data memory stage (load/store, driven by the memory controller's active-low strobe, rw, word address and write data). It grants one owner at a time, registers that owner's transaction onto the bus, waits for memory ready with a bounded timeout, and returns read data and a one-cycle ready to the owner. It sits between the pipeline's IF/MEM stages and the memory/bus slave.

## Interface
- ADDR_W, 30, word-address width (byte offset is stripped upstream)
- DATA_W, 32, data width
- TIMEOUT, 16, maximum wait cycles per transaction before abort (≥2)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_as_  in  1  fetch request strobe, active-low
- if_addr  in  ADDR_W  fetch word address
- if_rd_data  out  DATA_W  fetch read data, valid when if_rdy=1
- if_rdy  out  1  fetch transaction done (one-cycle pulse)
- mem_as_  in  1  data request strobe, active-low
- mem_rw  in  1  `READ`/`WRITE`
- mem_addr  in  ADDR_W  data word address
- mem_wr_data  in  DATA_W  store data
- mem_rd_data  out  DATA_W  load data, valid when mem_rdy=1
- mem_rdy  out  1  data transaction done (one-cycle pulse)
- bus_as_  out  1  bus strobe, active-low, registered
- bus_rw  out  1  registered `READ`/`WRITE`
- bus_addr  out  ADDR_W  registered address
- bus_wr_data  out  DATA_W  registered write data
- bus_rd_data  in  DATA_W  memory read data
- bus_rdy  in  1  memory completes current access
- bus_err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, OWN_IF, OWN_MEM.
- IDLE: if_as_=0 only → OWN_IF; mem_as_=0 only → OWN_MEM; both → grant the requester not granted last (last_grant flop; reset value IF, so first contention goes to MEM). No request → stay.
- On grant: latch addr/rw/wr_data into bus_* and drive bus_as_=0. IF grant forces bus_rw=`READ` and bus_wr_data=0.
- OWN_x with bus_rdy=1: x_rdy=1 that cycle, x_rd_data=bus_rd_data (combinational pass-through); next state IDLE, bus_as_=1; last_grant←x.
- Wait counter: cleared on grant, +1 each OWN cycle with bus_rdy=0. When counter=TIMEOUT-1 and bus_rdy=0: abort — x_rdy=1, x_rd_data=0, bus_err=1 for that cycle; next IDLE.
- x_rd_data is 0 whenever x_rdy=0. The non-owner's rdy stays 0.
- Requester must hold strobe and fields until its rdy; fields are sampled only at grant. A strobe withdrawn mid-transaction does not abort: the access completes and rdy still pulses.
- Reset (any cycle, incl. mid-transaction): state IDLE, bus_as_=1, bus_rw=`READ`, bus_addr=0, bus_wr_data=0, counter=0, last_grant=IF, if_rdy=mem_rdy=bus_err=0; the interrupted transaction gets no rdy.

## Timing
- Request seen in IDLE at cycle t → bus_as_=0 at t+1.
- Zero-wait memory (bus_rdy=1 at t+1) → x_rdy at t+1; bus_as_=1 at t+2. Minimum 2 cycles/transaction, one IDLE cycle between transactions.
- n wait cycles → x_rdy at t+1+n, for n ≤ TIMEOUT-2; no bus_rdy by t+TIMEOUT → abort pulse at t+TIMEOUT.
- bus_rdy at the abort cycle wins: normal completion, no bus_err.
- bus_rdy while IDLE is ignored.

## Structure
- Into `define.v`: `READ`/`WRITE`, `ENABLE_`/`DISABLE_`, state encodings `BUS_OWNER_IDLE/IF/MEM`, owner encodings for last_grant.
- One sub-module: `bus_wait_timer` (TIMEOUT-parameterized counter, clear/enable inputs, expire output).

## Test plan
- IF read, 0 waits: if_as_=0, if_addr=0x100, bus_rd_data=0xDEADBEEF → bus_as_ low at t+1, bus_rw=`READ`, if_rdy at t+1 with 0xDEADBEEF.
- Store with 3 waits: mem_rw=`WRITE`, mem_addr=0x40, data=0x12345678 → bus fields held 4 cycles, mem_rdy at t+4, bus_as_ high at t+5.
- Contention: both strobes held from reset → grant sequence MEM, IF, MEM, IF; each rdy goes only to its owner.
- Timeout: TIMEOUT=16, bus_rdy never → mem_rdy=1, bus_err=1, mem_rd_data=0 at t+16; IDLE after; next request serviced normally.
- Boundary: bus_rdy first asserted at t+16 → normal completion, bus_err=0.
- Reset asserted at t+2 of a waiting transaction → all outputs to reset values immediately, no rdy; post-reset request served with last_grant=IF.
